// File: rtl/ws281x_pkg.sv
// Constants and state encoding shared by the WS281X receive and transmit ends.
package ws281x_pkg;

  localparam int PIXEL_W       = 24;
  localparam int T_THRESH_DEF  = 12;
  localparam int T_MAXHIGH_DEF = 40;
  localparam int T_LATCH_DEF   = 1000;
  localparam int CNT_W_DEF     = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/ws281x_sync.sv
// Two-flop synchronizer for the raw WS281X line, plus a history flop and
// registered single-cycle rise/fall strobes aligned with the delayed level.
module ws281x_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      hist <= sync;
      rise <= sync & ~hist;
      fall <= ~sync & hist;
    end
  end

  // level is the line value in the same cycle the matching edge strobe is seen
  assign level = hist;

endmodule

// File: rtl/ws281x_rx.sv
// WS281X receiver: times each high pulse to recover bits, packs them MSB-first
// into pixel words, and reports latch gaps, over-long pulses and overruns.
module ws281x_rx
  import ws281x_pkg::*;
#(
  parameter int WIDTH     = PIXEL_W,
  parameter int T_THRESH  = T_THRESH_DEF,
  parameter int T_MAXHIGH = T_MAXHIGH_DEF,
  parameter int T_LATCH   = T_LATCH_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Din,
  output logic [WIDTH-1:0] Q,
  output logic             Valid,
  input  logic             Ready,
  output logic [15:0]      PixelNum,
  output logic             Frame,
  output logic             Error,
  output logic             Overrun
);

  localparam int BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] THRESH    = CNT_W'(T_THRESH);
  localparam logic [CNT_W-1:0] MAXHIGH   = CNT_W'(T_MAXHIGH);
  localparam logic [CNT_W-1:0] LATCH     = CNT_W'(T_LATCH);
  localparam logic [CNT_W-1:0] LATCH_M1  = CNT_W'(T_LATCH - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WIDTH - 1);

  logic             level;
  logic             rise;
  logic             fall;

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bitcnt;
  logic [15:0]      word_idx;
  logic [WIDTH-1:0] shreg;

  logic             bit_val;
  logic [WIDTH-1:0] shifted;
  logic             can_load;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  ws281x_sync u_sync (
    .clk   (Clock),
    .rst_n (Reset_n),
    .din   (Din),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign bit_val  = (cnt >= THRESH);
  assign shifted  = {shreg[WIDTH-2:0], bit_val};
  assign can_load = ~Valid | Ready;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bitcnt   <= '0;
      word_idx <= '0;
      shreg    <= '0;
      Q        <= '0;
      Valid    <= 1'b0;
      PixelNum <= '0;
      Frame    <= 1'b0;
      Error    <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      Frame   <= 1'b0;
      Error   <= 1'b0;
      Overrun <= 1'b0;

      // a word load later in this block overrides the consume
      if (Valid && Ready) begin
        Valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (level) begin
            cnt <= '0;
          end else if (cnt == LATCH_M1) begin
            state    <= WAIT;
            cnt      <= LATCH;
            bitcnt   <= '0;
            word_idx <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        WAIT: begin
          if (rise) begin
            state <= HIGH;
            cnt   <= CNT_ONE;
          end else begin
            if (cnt == LATCH_M1) begin
              Frame    <= 1'b1;
              bitcnt   <= '0;
              word_idx <= '0;
            end
            cnt <= sat_inc(cnt);
          end
        end

        HIGH: begin
          if (cnt > MAXHIGH) begin
            Error  <= 1'b1;
            bitcnt <= '0;
            state  <= IDLE;
            cnt    <= '0;
          end else if (fall) begin
            shreg <= shifted;
            state <= LOW;
            cnt   <= CNT_ONE;
            if (bitcnt == LAST_BIT) begin
              bitcnt   <= '0;
              word_idx <= word_idx + 16'd1;
              if (can_load) begin
                Q        <= shifted;
                Valid    <= 1'b1;
                PixelNum <= word_idx;
              end else begin
                Overrun <= 1'b1;
              end
            end else begin
              bitcnt <= bitcnt + BIT_W'(1);
            end
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        LOW: begin
          if (rise) begin
            state <= HIGH;
            cnt   <= CNT_ONE;
          end else if (cnt == LATCH_M1) begin
            Frame    <= 1'b1;
            bitcnt   <= '0;
            word_idx <= '0;
            state    <= WAIT;
            cnt      <= LATCH;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws281x_rx.sv
// Directed bench for ws281x_rx: drives pulse-width encoded bits and checks
// received words, pixel indices and status pulses against hand-derived values.
module tb_ws281x_rx;

  logic        Clock;
  logic        Reset_n;
  logic        Din;
  logic [23:0] Q;
  logic        Valid;
  logic        Ready;
  logic [15:0] PixelNum;
  logic        Frame;
  logic        Error;
  logic        Overrun;

  int n_chk;
  int n_pass;
  int frame_cnt;
  int err_cnt;
  int ovr_cnt;
  int valid_cycles;
  logic [23:0] got_q[$];
  logic [15:0] got_pn[$];

  ws281x_rx dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Din      (Din),
    .Q        (Q),
    .Valid    (Valid),
    .Ready    (Ready),
    .PixelNum (PixelNum),
    .Frame    (Frame),
    .Error    (Error),
    .Overrun  (Overrun)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (Reset_n) begin
      if (Frame)   frame_cnt++;
      if (Error)   err_cnt++;
      if (Overrun) ovr_cnt++;
      if (Valid)   valid_cycles++;
      if (Valid && Ready) begin
        got_q.push_back(Q);
        got_pn.push_back(PixelNum);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_word(input string tag, input int idx, input logic [23:0] exp_q,
                            input logic [15:0] exp_pn);
    if (got_q.size() > idx) begin
      check({tag, "_q"}, got_q[idx], exp_q);
      check({tag, "_pn"}, got_pn[idx], exp_pn);
    end else begin
      check({tag, "_missing"}, 32'hDEAD_BEEF, exp_q);
    end
  endtask

  task automatic clr();
    frame_cnt    = 0;
    err_cnt      = 0;
    ovr_cnt      = 0;
    valid_cycles = 0;
    got_q.delete();
    got_pn.delete();
  endtask

  task automatic hold_low(input int n);
    Din = 1'b0;
    repeat (n) @(negedge Clock);
  endtask

  task automatic send_pulse(input int hi, input int lo);
    Din = 1'b1;
    repeat (hi) @(negedge Clock);
    Din = 1'b0;
    repeat (lo) @(negedge Clock);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_pulse(16, 9);
    else   send_pulse(6, 19);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    Din     = 1'b0;
    Ready   = 1'b1;
    Reset_n = 1'b0;
    clr();
    repeat (3) @(negedge Clock);
    check("rst_valid", Valid, 0);
    check("rst_q", Q, 0);
    check("rst_pn", PixelNum, 0);
    check("rst_frame", Frame, 0);
    check("rst_error", Error, 0);
    check("rst_overrun", Overrun, 0);
    Reset_n = 1'b1;
    hold_low(1000);

    // single word, consumer always ready
    clr();
    send_word(24'hA5C3F0);
    hold_low(30);
    check("t1_nwords", got_q.size(), 1);
    check_word("t1", 0, 24'hA5C3F0, 16'd0);
    check("t1_valid_cycles", valid_cycles, 1);
    check("t1_valid_now", Valid, 0);
    hold_low(1100);
    check("t1_frame", frame_cnt, 1);

    // three words, latch gap, then index restarts
    clr();
    send_word(24'h000001);
    send_word(24'h800000);
    send_word(24'hFFFFFF);
    hold_low(1100);
    check("t2_nwords", got_q.size(), 3);
    check_word("t2_w0", 0, 24'h000001, 16'd0);
    check_word("t2_w1", 1, 24'h800000, 16'd1);
    check_word("t2_w2", 2, 24'hFFFFFF, 16'd2);
    check("t2_frame", frame_cnt, 1);
    clr();
    send_word(24'h0F0F0F);
    hold_low(30);
    check_word("t2_next", 0, 24'h0F0F0F, 16'd0);
    hold_low(1100);

    // consumer stalled: second word overruns, first stays held
    clr();
    Ready = 1'b0;
    send_word(24'h111111);
    send_word(24'h222222);
    hold_low(20);
    check("t3_valid", Valid, 1);
    check("t3_q", Q, 24'h111111);
    check("t3_pn", PixelNum, 0);
    check("t3_overrun", ovr_cnt, 1);
    Ready = 1'b1;
    @(negedge Clock);
    Ready = 1'b0;
    @(negedge Clock);
    check("t3_valid_drop", Valid, 0);
    check("t3_nwords", got_q.size(), 1);
    Ready = 1'b1;
    hold_low(1100);

    // threshold boundary: 11 clocks -> 0, 12 clocks -> 1
    clr();
    for (int i = 0; i < 22; i++) send_bit(1'b1);
    send_pulse(11, 13);
    send_pulse(12, 13);
    hold_low(30);
    check_word("t4", 0, 24'hFFFFFD, 16'd0);
    hold_low(1100);

    // over-long pulse aborts the word; recovery after a latch gap
    clr();
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    send_pulse(45, 0);
    hold_low(1100);
    check("t5_error", err_cnt, 1);
    check("t5_no_valid", valid_cycles, 0);
    check("t5_no_frame", frame_cnt, 0);
    send_word(24'h123456);
    hold_low(30);
    check("t5_nwords", got_q.size(), 1);
    check_word("t5", 0, 24'h123456, 16'd0);
    hold_low(1100);

    // asynchronous reset in the middle of bit 13
    clr();
    for (int i = 0; i < 13; i++) send_bit(1'b0);
    Din = 1'b1;
    repeat (5) @(negedge Clock);
    Reset_n = 1'b0;
    #1;
    check("t6_rst_q", Q, 0);
    check("t6_rst_valid", Valid, 0);
    @(negedge Clock);
    Reset_n = 1'b1;
    send_pulse(11, 9);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    hold_low(1100);
    check("t6_ignored", got_q.size(), 0);
    send_word(24'h654321);
    hold_low(30);
    check("t6_nwords", got_q.size(), 1);
    check_word("t6", 0, 24'h654321, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
